nes_tetris_soc_gp_pio: RTL and testbench

Parametrised general-purpose PIO Avalon-MM slave. Generalises the single-register output PIO used for the hex digits:
- output register with atomic set and clear writes;
- synchronised input port;
- per-bit edge capture with interrupt mask and level IRQ to the Nios II.

---
 rtl/nes_tetris_soc_gp_pio_if.sv | 19 +
 rtl/nes_tetris_soc_gp_pio.sv | 133 +++++++++++++
 tb/tb_nes_tetris_soc_gp_pio.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/nes_tetris_soc_gp_pio_if.sv
// Avalon-MM slave bus bundle for the general-purpose PIO: word address,
// select, active-low write strobe and 32-bit read/write data.
interface nes_tetris_soc_gp_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/nes_tetris_soc_gp_pio.sv
// General-purpose PIO: set/clear output register, synchronised inputs and masked
// per-bit edge capture with level IRQ. Optional input debounce: GP_PIO_DEBOUNCE_EN.
module nes_tetris_soc_gp_pio #(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned RESET_VALUE     = 0,
  parameter int unsigned EDGE_TYPE       = 0,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  nes_tetris_soc_gp_pio_if.slave bus,
  input  logic [DATA_WIDTH-1:0]  in_port,
  output logic [DATA_WIDTH-1:0]  out_port,
  output logic                   irq
);

  localparam logic [DATA_WIDTH-1:0] RST_VAL = DATA_WIDTH'(RESET_VALUE);
`ifdef GP_PIO_DEBOUNCE_EN
  localparam int unsigned GUARD_CYCLES = SYNC_STAGES + 1 + DEBOUNCE_CYCLES;
`else
  localparam int unsigned GUARD_CYCLES = SYNC_STAGES + 1;
`endif
  localparam logic [8:0] GUARD_END = 9'(GUARD_CYCLES);

  localparam logic [2:0] A_DATA_OUT  = 3'd0;
  localparam logic [2:0] A_DATA_IN   = 3'd1;
  localparam logic [2:0] A_IRQ_MASK  = 3'd2;
  localparam logic [2:0] A_EDGE_CAP  = 3'd3;
  localparam logic [2:0] A_OUTSET    = 3'd4;
  localparam logic [2:0] A_OUTCLEAR  = 3'd5;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wd;
  logic                  wd_unused;
  logic [DATA_WIDTH-1:0] data_out, irq_mask, edge_capture, prev;
  logic [DATA_WIDTH-1:0] sync_in, filt_in, rise, fall, edge_sel, w1c;
  logic [DATA_WIDTH-1:0] rd_val;
  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_p;
  logic [8:0]            guard_cnt;
  logic                  guard_done;

  assign wr_en     = bus.chipselect && !bus.write_n;
  assign wd        = bus.writedata[DATA_WIDTH-1:0];
  assign wd_unused = ^bus.writedata;

  // ---- stage p0..pN: input synchroniser chain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_p <= '0;
    else          sync_p <= {sync_p[SYNC_STAGES-2:0], in_port};
  end
  assign sync_in = sync_p[SYNC_STAGES-1];

  // ---- filter stage: sync_in -> filt_in
`ifdef GP_PIO_DEBOUNCE_EN
  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  logic [DATA_WIDTH-1:0][7:0] deb_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_in <= '0;
      deb_cnt <= '0;
    end else begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        if (sync_in[i] == filt_in[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          filt_in[i] <= sync_in[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 8'd1;
        end
      end
    end
  end
`else
  assign filt_in = sync_in;
`endif

  // Edges are ignored until the input pipeline has flushed its reset contents.
  assign guard_done = (guard_cnt == GUARD_END);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         guard_cnt <= '0;
    else if (!guard_done) guard_cnt <= guard_cnt + 9'd1;
  end

  always_comb begin
    rise = filt_in & ~prev;
    fall = ~filt_in & prev;
    if (EDGE_TYPE == 0)      edge_sel = rise;
    else if (EDGE_TYPE == 1) edge_sel = fall;
    else                     edge_sel = rise | fall;
    w1c = (wr_en && bus.address == A_EDGE_CAP) ? wd : '0;
  end

  // ---- register stage: outputs, mask, capture (set beats W1C)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out     <= RST_VAL;
      irq_mask     <= '0;
      edge_capture <= '0;
      prev         <= '0;
    end else begin
      prev         <= filt_in;
      edge_capture <= (edge_capture & ~w1c) | (guard_done ? edge_sel : '0);
      if (wr_en) begin
        case (bus.address)
          A_DATA_OUT: data_out <= wd;
          A_OUTSET:   data_out <= data_out | wd;
          A_OUTCLEAR: data_out <= data_out & ~wd;
          A_IRQ_MASK: irq_mask <= wd;
          default:    ;
        endcase
      end
    end
  end

  always_comb begin
    rd_val = '0;
    case (bus.address)
      A_DATA_OUT: rd_val = data_out;
      A_DATA_IN:  rd_val = filt_in;
      A_IRQ_MASK: rd_val = irq_mask;
      A_EDGE_CAP: rd_val = edge_capture;
      default:    rd_val = '0;
    endcase
    bus.readdata = 32'(rd_val);
  end

  assign out_port = data_out;
  assign irq      = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_nes_tetris_soc_gp_pio.sv
// Directed bench for nes_tetris_soc_gp_pio: default instance plus a narrow
// any-edge instance with non-zero reset value.
module tb_nes_tetris_soc_gp_pio;
`ifdef GP_PIO_DEBOUNCE_EN
  localparam int FD = 8;
`else
  localparam int FD = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] in_port = '0;
  logic [15:0] out_port;
  logic        irq;
  logic [7:0]  in_port2 = '0;
  logic [7:0]  out_port2;
  logic        irq2;
  logic [31:0] v;
  int          total = 0;
  int          passed = 0;
  int          failed = 0;

  always #5 clk = ~clk;

  nes_tetris_soc_gp_pio_if bus ();
  nes_tetris_soc_gp_pio_if bus2 ();

  nes_tetris_soc_gp_pio u_dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave),
    .in_port(in_port), .out_port(out_port), .irq(irq)
  );

  nes_tetris_soc_gp_pio #(
    .DATA_WIDTH(8), .RESET_VALUE(32'h5A), .EDGE_TYPE(2), .SYNC_STAGES(3)
  ) u_any (
    .clk(clk), .reset_n(reset_n), .bus(bus2.slave),
    .in_port(in_port2), .out_port(out_port2), .irq(irq2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(posedge clk); #1;
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic chk_rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
    #1; v = bus.readdata;
    check(tag, v, exp);
  endtask

  task automatic wr2(input logic [2:0] a, input logic [31:0] d);
    bus2.address = a; bus2.writedata = d; bus2.chipselect = 1'b1; bus2.write_n = 1'b0;
    @(posedge clk); #1;
    bus2.chipselect = 1'b0; bus2.write_n = 1'b1;
  endtask

  task automatic chk_rd2(input string tag, input logic [2:0] a, input logic [31:0] exp);
    bus2.address = a; bus2.chipselect = 1'b1; bus2.write_n = 1'b1;
    #1; v = bus2.readdata;
    check(tag, v, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    bus2.address = '0; bus2.chipselect = 1'b0; bus2.write_n = 1'b1; bus2.writedata = '0;

    // Reset state, inputs held high through reset.
    in_port = 16'hFFFF;
    tick(2);
    check("rst_out_port", 32'(out_port), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_out_port2", 32'(out_port2), 32'h5A);
    chk_rd("rst_rd_data_out", 3'd0, 32'h0);
    chk_rd("rst_rd_mask", 3'd2, 32'h0);
    chk_rd("rst_rd_cap", 3'd3, 32'h0);
    tick(1);
    reset_n = 1'b1;
    wr(3'd2, 32'hFFFF);
    tick(10);
    chk_rd("guard_cap", 3'd3, 32'h0);
    check("guard_irq", 32'(irq), 32'h0);
    chk_rd("guard_data_in", 3'd1, 32'hFFFF);

    // Falling edges are not captured with rising-edge selection.
    in_port = 16'h0000;
    tick(4 + FD);
    chk_rd("fall_ignored_cap", 3'd3, 32'h0);
    chk_rd("fall_data_in", 3'd1, 32'h0);

    // Output register: load, set, clear, ignored writes.
    wr(3'd0, 32'hA5A5);
    check("load_out_port", 32'(out_port), 32'hA5A5);
    chk_rd("load_rd", 3'd0, 32'h0000A5A5);
    wr(3'd4, 32'h000F);
    check("outset", 32'(out_port), 32'hA5AF);
    wr(3'd5, 32'h00A0);
    check("outclear", 32'(out_port), 32'hA50F);
    chk_rd("rd_outset_zero", 3'd4, 32'h0);
    chk_rd("rd_outclear_zero", 3'd5, 32'h0);
    chk_rd("rd_rsvd6", 3'd6, 32'h0);
    chk_rd("rd_rsvd7", 3'd7, 32'h0);
    wr(3'd1, 32'hFFFF);
    chk_rd("data_in_wr_ignored", 3'd1, 32'h0);
    wr(3'd6, 32'hFFFF);
    check("rsvd_wr_ignored", 32'(out_port), 32'hA50F);
    wr(3'd0, 32'hFFFF_0000);
    chk_rd("upper_bits_ignored", 3'd0, 32'h0);

    // Rising edge on bit 3: DATA_IN at N+2, capture/irq at N+3.
    wr(3'd2, 32'h0008);
    in_port = 16'h0008;
    tick(1 + FD);
    chk_rd("edge_din_n1", 3'd1, 32'h0);
    tick(1);
    chk_rd("edge_din_n2", 3'd1, 32'h0008);
    chk_rd("edge_cap_n2", 3'd3, 32'h0);
    check("edge_irq_n2", 32'(irq), 32'h0);
    tick(1);
    chk_rd("edge_cap_n3", 3'd3, 32'h0008);
    check("edge_irq_n3", 32'(irq), 32'h1);

    // W1C, set-wins collision, partial clear, mask/unmask.
    wr(3'd3, 32'h0008);
    chk_rd("w1c_cap", 3'd3, 32'h0);
    check("w1c_irq", 32'(irq), 32'h0);
    in_port = 16'h0018;
    tick(2 + FD);
    wr(3'd3, 32'h0010);
    chk_rd("set_wins", 3'd3, 32'h0010);
    in_port = 16'h0058;
    tick(3 + FD);
    chk_rd("two_bits", 3'd3, 32'h0050);
    wr(3'd3, 32'h0010);
    chk_rd("partial_w1c", 3'd3, 32'h0040);
    check("masked_irq", 32'(irq), 32'h0);
    wr(3'd2, 32'h0040);
    check("unmask_irq", 32'(irq), 32'h1);
    wr(3'd2, 32'h0000);
    check("remask_irq", 32'(irq), 32'h0);

    // Asynchronous reset mid-operation.
    wr(3'd3, 32'hFFFF);
    wr(3'd0, 32'h1234);
    in_port = 16'h0059;
    tick(3 + FD);
    chk_rd("pre_rst_cap", 3'd3, 32'h0001);
    check("pre_rst_out", 32'(out_port), 32'h1234);
    wr(3'd2, 32'h0001);
    check("pre_rst_irq", 32'(irq), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_out_port", 32'(out_port), 32'h0);
    check("arst_irq", 32'(irq), 32'h0);
    check("arst_out_port2", 32'(out_port2), 32'h5A);
    chk_rd("arst_rd_out", 3'd0, 32'h0);
    chk_rd("arst_rd_mask", 3'd2, 32'h0);
    chk_rd("arst_rd_cap", 3'd3, 32'h0);
    tick(2);
    reset_n = 1'b1;
    wr(3'd2, 32'hFFFF);
    tick(6 + FD);
    chk_rd("reguard_cap", 3'd3, 32'h0);
    chk_rd("reguard_din", 3'd1, 32'h0059);
    check("reguard_irq", 32'(irq), 32'h0);

`ifdef GP_PIO_DEBOUNCE_EN
    // Debounce: short glitch rejected, long pulse accepted after 2+8 cycles.
    in_port = 16'h0000;
    tick(14);
    wr(3'd3, 32'hFFFF);
    in_port = 16'h0001;
    tick(3);
    in_port = 16'h0000;
    tick(12);
    chk_rd("glitch_din", 3'd1, 32'h0);
    chk_rd("glitch_cap", 3'd3, 32'h0);
    in_port = 16'h0001;
    tick(9);
    chk_rd("pulse_din_9", 3'd1, 32'h0);
    tick(1);
    chk_rd("pulse_din_10", 3'd1, 32'h0001);
    in_port = 16'h0000;
    tick(1);
    chk_rd("pulse_cap", 3'd3, 32'h0001);
`endif

    // Narrow any-edge instance: width truncation and both edge directions.
    wr2(3'd0, 32'hFFFF_FFFF);
    chk_rd2("any_rd_out", 3'd0, 32'h0000_00FF);
    check("any_out_port", 32'(out_port2), 32'hFF);
    wr2(3'd2, 32'hFF);
    in_port2 = 8'h02;
    tick(3 + FD);
    chk_rd2("any_rise_n3", 3'd3, 32'h0);
    tick(1);
    chk_rd2("any_rise_n4", 3'd3, 32'h02);
    check("any_rise_irq", 32'(irq2), 32'h1);
    wr2(3'd3, 32'h02);
    chk_rd2("any_w1c", 3'd3, 32'h0);
    check("any_w1c_irq", 32'(irq2), 32'h0);
    in_port2 = 8'h00;
    tick(4 + FD);
    chk_rd2("any_fall", 3'd3, 32'h02);
    chk_rd2("any_din", 3'd1, 32'h0);
    chk_rd2("any_rsvd5", 3'd5, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
